// File: rtl/mul_share_pkg.sv
// Shared types and widths for the Multi_8b sharing controller.
package mul_share_pkg;

    localparam int OP_W   = 8;
    localparam int RES_W  = 16;
    localparam int GIDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Round-robin pointer advances to the requester after the one just served.
    function automatic logic [GIDX_W-1:0] next_ptr(input logic [GIDX_W-1:0] id, input int nreq);
        return (int'(id) == nreq - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]   i_req,
    input  logic [GIDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]   o_grant,
    output logic [GIDX_W-1:0] o_idx,
    output logic              o_any
);

    logic [NREQ-1:0] w_rot;
    int              w_pos;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int j = 0; j < NREQ; j++) begin
            if (!o_any && w_rot[j]) begin
                o_any = 1'b1;
                w_pos = int'(i_ptr) + j;
                if (w_pos >= NREQ) w_pos = w_pos - NREQ;
                o_idx = GIDX_W'(w_pos);
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_any && (o_idx == GIDX_W'(i));
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one Multi_8b sequential multiplier between NREQ requesters, with round-robin
// grant, operand latching and a watchdog that resets a hung multiplier.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operands on the next edge
// ISSUE | mul_start high for this one cycle; wait counter cleared
// WAIT  | counting; fim accepted from the second cycle, abort at TIMEOUT
// DONE  | one-cycle response pulse to the served requester, pointer advances
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [OP_W*NREQ-1:0] req_a,
    input  logic [OP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      resp_valid,
    output logic [RES_W-1:0]     resp_result,
    output logic                 resp_z,
    output logic                 resp_ov,
    output logic                 resp_err,
    output logic                 busy,
    output logic [GIDX_W-1:0]    grant_id,
    output logic                 mul_start,
    output logic                 mul_rst,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic [RES_W-1:0]     mul_result,
    input  logic                 mul_fim,
    input  logic                 mul_z,
    input  logic                 mul_ov
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [GIDX_W-1:0]  r_ptr;
    logic [GIDX_W-1:0]  r_grant_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic               r_start;
    logic [NREQ-1:0]    r_valid;
    logic [RES_W-1:0]   r_result;
    logic               r_z;
    logic               r_ov;
    logic               r_err;
    logic               r_err_pulse;

    logic [NREQ-1:0]    w_grant;
    logic [GIDX_W-1:0]  w_idx;
    logic               w_any;
    logic [OP_W-1:0]    w_op_a;
    logic [OP_W-1:0]    w_op_b;
    logic [NREQ-1:0]    w_dec;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op_a = req_a[OP_W*i +: OP_W];
                w_op_b = req_b[OP_W*i +: OP_W];
            end
        end
    end

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dec[i] = (r_grant_id == GIDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_start     <= 1'b0;
            r_valid     <= '0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_ov        <= 1'b0;
            r_err       <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_valid     <= '0;
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_idx;
                        r_a        <= w_op_a;
                        r_b        <= w_op_b;
                        r_start    <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A fim level left over from the previous op is ignored on the first cycle.
                    if ((r_cnt != '0) && mul_fim) begin
                        r_result <= mul_result;
                        r_z      <= mul_z;
                        r_ov     <= mul_ov;
                        r_err    <= 1'b0;
                        r_valid  <= w_dec;
                        r_state  <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_result    <= '0;
                        r_z         <= 1'b0;
                        r_ov        <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_pulse <= 1'b1;
                        r_valid     <= w_dec;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ptr      <= next_ptr(r_grant_id, NREQ);
                    r_grant_id <= '0;
                    r_result   <= '0;
                    r_z        <= 1'b0;
                    r_ov       <= 1'b0;
                    r_err      <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign grant_id    = r_grant_id;
    assign mul_start   = r_start;
    assign mul_rst     = ~rst | r_err_pulse;
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign resp_valid  = r_valid;
    assign resp_result = r_result;
    assign resp_z      = r_z;
    assign resp_ov     = r_ov;
    assign resp_err    = r_err;

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Round-robin scheduler that shares one Multi_8b 8x8 sequential multiplier between NREQ independent requesters.
- Each requester presents operands with a level request and receives a one-cycle response pulse carrying Result/Z/OV.
- The block sequences the multiplier's start/fimOperacao handshake, latches operands for the duration of an operation, and recovers from a hung multiplier via a watchdog.
- Sits between client blocks and a single Multi_8b instance in the arithmetic subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max WAIT cycles before abort (must be > worst-case multiplier latency)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req  in  NREQ  per-requester request level; operands must stay stable while high
- req_a  in  8*NREQ  operand A, requester i at [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- resp_valid  out  NREQ  one-hot, one-cycle completion pulse to the served requester
- resp_result  out  16  product, valid with resp_valid
- resp_z  out  1  zero flag from multiplier, valid with resp_valid
- resp_ov  out  1  overflow flag from multiplier, valid with resp_valid
- resp_err  out  1  1 = watchdog abort; result forced 0, valid with resp_valid
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of requester currently being served (0 when idle)
- mul_start  out  1  to Multi_8b start
- mul_rst  out  1  to Multi_8b rst (active-high)
- mul_a  out  8  to Multi_8b A
- mul_b  out  8  to Multi_8b B
- mul_result  in  16  from Multi_8b Result
- mul_fim  in  1  from Multi_8b fimOperacao
- mul_z  in  1  from Multi_8b Z
- mul_ov  in  1  from Multi_8b OV

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except mul_rst=1; rr pointer=0; wait counter=0.
- mul_rst = ~rst OR err_pulse_q, where err_pulse_q is a registered 1-cycle pulse issued on abort.
- FSM states:
  - IDLE: if any req bit set, grant the first set bit at or after the pointer (wrapping). Latch index into grant_id, latch that requester's operands into mul_a/mul_b, then go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; clear wait counter; go to WAIT.
  - WAIT: increment counter. mul_fim is ignored in the first WAIT cycle, which guards against a stale fimOperacao level from the previous op. From counter>=1, mul_fim=1 captures mul_result/mul_z/mul_ov and goes to DONE. If the counter reaches TIMEOUT first: set resp_err, result=0, z=0, ov=0, pulse mul_rst, go to DONE.
  - DONE: resp_valid[grant_id]=1 for one cycle with latched response. Pointer = grant_id+1 mod NREQ. Go to IDLE.
- mul_a/mul_b hold the latched operands from ISSUE through DONE; requester operand changes mid-op have no effect.
- Minimum service latency: request seen in IDLE cycle N → mul_start at N+1 → resp_valid at (fim cycle)+1.
- Back-to-back: a requester holding req after its pulse is re-served only after any other pending requesters (fairness). If it is the sole requester, it is re-granted in the next IDLE cycle.
- req drop while served: operation completes and the pulse is still issued; the requester must ignore it.
- Simultaneous requests: exactly one grant per IDLE cycle, round-robin from the pointer.
- Reset mid-operation: immediate abort, no resp_valid, pointer returns to 0.
- No arithmetic in this block; widths are pass-through.

Decomposition:
- Package mul_share_pkg: state encoding (IDLE, ISSUE, WAIT, DONE), operand width 8, result width 16, grant index width 3.
- Sub-module rr_arbiter: NREQ request vector + pointer in → one-hot grant and index out, purely combinational.
- FSM, latches and watchdog stay in mul_share_ctrl. The Multi_8b instance lives in the parent.

Test Plan:
- Single request: req[0]=1, A=5, B=10 → one mul_start pulse; resp_valid=4'b0001, resp_result=50, resp_err=0.
- Zero product: req[2], A=0, B=0 → resp_result=0, resp_z=1, grant_id=2.
- Contention: req=4'b1111 at once, operands (3,4),(255,255),(128,2),(1,200) → pulses in order 0,1,2,3 with results 12, 65025, 256, 200.
- Fairness: req[1] held high continuously plus req[3] pulsed → service order 1,3,1; never 1,1 while req[3] pending.
- Watchdog: stub multiplier never asserts fim → resp_valid after TIMEOUT WAIT cycles with resp_err=1, result=0, one-cycle mul_rst pulse; the next request then completes normally.
- Reset mid-WAIT: drop rst → busy=0, mul_rst=1, no resp_valid. After release, the pending request is re-served from pointer 0.
